// File: rtl/mrf_pkg.sv
// mrf_pkg - shared types and sizing helpers for the mRF feeder slice.
//
// Contents:
//   mrf_feeder_state_t : feeder sequencer states
//   MRF_WORDWIDTH / MRF_NUM1 / MRF_CHANNEL : default geometry
//   mrf_total()        : words per frame (CHANNEL*NUM1)
//   mrf_cw()           : width of the sequence index for a given frame size
package mrf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } mrf_feeder_state_t;

    localparam int MRF_WORDWIDTH = 32;
    localparam int MRF_NUM1      = 5;
    localparam int MRF_CHANNEL   = 6;

    function automatic int mrf_total(input int channel, input int num1);
        return channel * num1;
    endfunction

    // A one-entry frame would give $clog2()==0; keep at least one bit.
    function automatic int mrf_cw(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/mrf_feeder_if.sv
// mrf_feeder_if - valid/ready word stream between the weight/activation
// buffer and the mRF feeder.
//
// Signals:
//   in_valid  : source has a word
//   in_data   : the word (WORDWIDTH bits)
//   in_ready  : feeder accepts the word this cycle
// Modports:
//   master : the upstream buffer (drives valid/data)
//   slave  : the feeder (drives ready)
interface mrf_feeder_if
    import mrf_pkg::*;
#(
    parameter int WORDWIDTH = MRF_WORDWIDTH
);

    logic                 in_valid;
    logic [WORDWIDTH-1:0] in_data;
    logic                 in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/mrf_word_counter.sv
// mrf_word_counter - sequence index for the register-file write port.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   i_clr      : synchronous clear to 0
//   i_inc      : advance by one (ignored once the last index is reached)
//   o_count    : current index
//   o_terminal : index equals TOTAL-1
module mrf_word_counter
    import mrf_pkg::*;
#(
    parameter int TOTAL = 30,
    parameter int CW    = mrf_cw(TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_count,
    output logic          o_terminal
);

    localparam logic [CW-1:0] LP_LAST = CW'(TOTAL - 1);

    logic [CW-1:0] r_count;
    logic          w_terminal;

    assign w_terminal = (r_count == LP_LAST);

    // Saturates at the last index so the register file never sees a wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = w_terminal;

endmodule

// File: rtl/mrf_feeder.sv
// mrf_feeder - drives the count/reg_data write port of the mRF register-file
// slices from a valid/ready word stream. Each frame is one clear cycle
// (count=0, reg_data=0) followed by TOTAL-1 words on count=1..TOTAL-1.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin a frame (only looked at in IDLE)
//   abort    : drop the current frame (only with MRF_FEEDER_ABORT_EN)
//   s_in     : upstream word stream (slave side)
//   count    : register-file sequence index, registered
//   reg_data : register-file write data, registered
//   busy     : high in CLEAR and STREAM
//   done     : one-cycle pulse at frame end
//
// Build option: define MRF_FEEDER_ABORT_EN to add the abort input.
//
//   state  | meaning
//   IDLE   | outputs hold, waiting for start
//   CLEAR  | one cycle: count and reg_data forced to 0
//   STREAM | in_ready high, each accepted word advances count
//   DONE   | one cycle: done pulse, then back to IDLE
module mrf_feeder
    import mrf_pkg::*;
#(
    parameter  int WORDWIDTH = MRF_WORDWIDTH,
    parameter  int NUM1      = MRF_NUM1,
    parameter  int CHANNEL   = MRF_CHANNEL,
    localparam int TOTAL     = mrf_total(CHANNEL, NUM1),
    localparam int CW        = mrf_cw(TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef MRF_FEEDER_ABORT_EN
    input  logic                 abort,
`endif
    mrf_feeder_if.slave          s_in,
    output logic [CW-1:0]        count,
    output logic [WORDWIDTH-1:0] reg_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CW-1:0] LP_PENULT = CW'(TOTAL - 2);

    mrf_feeder_state_t    r_state;
    logic [WORDWIDTH-1:0] r_reg_data;
    logic                 r_busy;
    logic                 r_done;

    logic          w_abort;
    logic          w_active;
    logic          w_ready;
    logic          w_hs;
    logic          w_last;
    logic          w_clr;
    logic [CW-1:0] w_count;
    logic          w_terminal;

`ifdef MRF_FEEDER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_active = (r_state == CLEAR) || (r_state == STREAM);

    // Abort wins over a simultaneous word, so ready is withdrawn while it is up.
    assign w_ready = (r_state == STREAM) && !w_abort;
    assign w_hs    = s_in.in_valid && w_ready;

    // The handshake that loads TOTAL-1 is the last word of the frame.
    assign w_last = (w_count == LP_PENULT);

    assign w_clr = (r_state == CLEAR) || (w_abort && w_active);

    mrf_word_counter #(
        .TOTAL (TOTAL),
        .CW    (CW)
    ) u_word_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_inc      (w_hs && !w_terminal),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_reg_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_reg_data <= '0;
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_abort) begin
                        r_state    <= IDLE;
                        r_reg_data <= '0;
                        r_busy     <= 1'b0;
                    end else if (w_hs) begin
                        r_reg_data <= s_in.in_data;
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_in.in_ready = w_ready;
    assign count         = w_count;
    assign reg_data      = r_reg_data;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_mrf_feeder.sv
// tb_mrf_feeder - directed bench for mrf_feeder at default geometry
// (TOTAL=30). A frame-level reference model runs alongside the DUT and every
// output is compared to it on each falling edge; a few literal expectations
// per scenario pin the model itself.
module tb_mrf_feeder;
    import mrf_pkg::*;

    localparam int TOTAL = mrf_total(MRF_CHANNEL, MRF_NUM1);
    localparam int CW    = mrf_cw(TOTAL);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          drv_valid = 1'b0;
    logic [31:0]   drv_data = '0;
    logic [CW-1:0] count;
    logic [31:0]   reg_data;
    logic          busy;
    logic          done;

    mrf_feeder_if #(.WORDWIDTH(32)) s_if ();

    assign s_if.in_valid = drv_valid;
    assign s_if.in_data  = drv_data;

    mrf_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef MRF_FEEDER_ABORT_EN
        .abort    (abort),
`endif
        .s_in     (s_if),
        .count    (count),
        .reg_data (reg_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is "in progress" from an accepted start
    // until its last word; the first cycle of a frame is the clear cycle.
    int          m_count = 0;
    logic [31:0] m_data = '0;
    bit          m_in_frame = 1'b0;
    bit          m_cleared = 1'b0;
    bit          m_done = 1'b0;
    bit          m_rdy;

    always @(posedge clk) begin
        m_rdy = m_in_frame && m_cleared && !abort;
        if (rst) begin
            m_count = 0; m_data = '0; m_in_frame = 0; m_cleared = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_in_frame) begin
            if (start) begin
                m_in_frame = 1; m_cleared = 0;
            end
        end else if (abort) begin
            m_in_frame = 0; m_count = 0; m_data = '0;
        end else if (!m_cleared) begin
            m_cleared = 1; m_count = 0; m_data = '0;
        end else if (drv_valid && m_rdy) begin
            m_count = m_count + 1;
            m_data  = drv_data;
            if (m_count == TOTAL - 1) begin
                m_in_frame = 0; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",    64'(count),         64'(m_count));
            chk("reg_data", 64'(reg_data),      64'(m_data));
            chk("in_ready", 64'(s_if.in_ready), 64'(m_in_frame && m_cleared && !abort));
            chk("busy",     64'(busy),          64'(m_in_frame));
            chk("done",     64'(done),          64'(m_done));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One frame; words are 1..29 in order. Returns after the frame plus one
    // idle cycle with in_valid still high.
    task automatic run_frame(input bit gaps, input bit inject, input int exp_done_edge);
        int done_e = -1;
        int pulses = 0;
        start = 1'b1; drv_valid = 1'b0;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drv_valid = gaps ? (i % 2 == 0) : 1'b1;
            drv_data  = 32'(m_count + 1);
            start     = inject && (i == 10 || m_done);
            cycle();
            if (done) begin
                pulses++;
                if (done_e < 0) done_e = i + 1;
            end
            if (done_e >= 0 && i + 1 > done_e + 1) break;
        end
        start = 1'b0; drv_valid = 1'b0;
        chk("done_edge",   64'(done_e),   64'(exp_done_edge));
        chk("done_pulses", 64'(pulses),   64'd1);
        chk("end_count",   64'(count),    64'd29);
        chk("end_data",    64'(reg_data), 64'h1D);
    endtask

    initial begin
        // Reset while start and in_valid are both held high.
        rst = 1'b1; start = 1'b1; drv_valid = 1'b1; drv_data = 32'hFFFF_FFFF;
        cycle();
        chk_en = 1'b1;
        cycle();
        chk("rst_count",    64'(count),         64'd0);
        chk("rst_data",     64'(reg_data),      64'd0);
        chk("rst_in_ready", 64'(s_if.in_ready), 64'd0);
        chk("rst_busy",     64'(busy),          64'd0);
        chk("rst_done",     64'(done),          64'd0);
        rst = 1'b0; start = 1'b0; drv_valid = 1'b0;
        cycle();

        // Back-to-back: 29th word lands 30 edges after the start edge.
        run_frame(1'b0, 1'b0, 30);
        for (int i = 0; i < 3; i++) cycle();
        chk("hold_count", 64'(count),    64'd29);
        chk("hold_data",  64'(reg_data), 64'h1D);

        // in_valid toggling 1,0,1,...: words on every other edge.
        run_frame(1'b1, 1'b0, 59);
        cycle();

        // start pulsed mid-STREAM and during DONE is ignored.
        run_frame(1'b0, 1'b1, 30);
        for (int i = 0; i < 3; i++) cycle();
        chk("ign_busy",  64'(busy),  64'd0);
        chk("ign_count", 64'(count), 64'd29);

        // Reset mid-frame at count=12.
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drv_valid = 1'b1;
            drv_data  = 32'(m_count + 1);
            cycle();
            if (count == CW'(12)) break;
        end
        chk("pre_rst_count", 64'(count), 64'd12);
        rst = 1'b1;
        cycle();
        chk("mid_rst_count", 64'(count),    64'd0);
        chk("mid_rst_data",  64'(reg_data), 64'd0);
        chk("mid_rst_busy",  64'(busy),     64'd0);
        chk("mid_rst_done",  64'(done),     64'd0);
        rst = 1'b0; drv_valid = 1'b0;
        cycle();
        run_frame(1'b0, 1'b0, 30);
        cycle();

`ifdef MRF_FEEDER_ABORT_EN
        // Abort at count=7 with a word on offer.
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drv_valid = 1'b1;
            drv_data  = 32'(m_count + 1);
            cycle();
            if (count == CW'(7)) break;
        end
        chk("pre_abort_count", 64'(count), 64'd7);
        abort = 1'b1; drv_valid = 1'b1; drv_data = 32'h8;
        #1;
        chk("abort_ready", 64'(s_if.in_ready), 64'd0);
        cycle();
        abort = 1'b0; drv_valid = 1'b0;
        chk("abort_count", 64'(count),    64'd0);
        chk("abort_data",  64'(reg_data), 64'd0);
        chk("abort_busy",  64'(busy),     64'd0);
        chk("abort_done",  64'(done),     64'd0);
        for (int i = 0; i < 3; i++) cycle();
        run_frame(1'b0, 1'b0, 30);
        cycle();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mrf_feeder.md
# mrf_feeder

Sequencer that drives the `count`/`reg_data` write interface of the mRF register-file slices from a valid/ready word stream. Per frame: one clear cycle (`count`=0, which zeroes the slice register), then `CHANNEL*NUM1-1` data words on `count`=1..`CHANNEL*NUM1-1`. It sits between the accelerator's weight/activation buffer and the register-file bank.

## Interface
- `WORDWIDTH`, 32, data word width
- `NUM1`, 5, words per channel
- `CHANNEL`, 6, channels per frame; `TOTAL` = `CHANNEL*NUM1`, `CW` = `$clog2(TOTAL)`
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a frame; sampled only in IDLE
- `in_valid`  in  1  upstream word valid
- `in_data`  in  WORDWIDTH  upstream word
- `in_ready`  out  1  upstream word accepted when `in_valid && in_ready`
- `count`  out  CW  register-file sequence index, registered
- `reg_data`  out  WORDWIDTH  register-file write data, registered
- `busy`  out  1  high in CLEAR and STREAM
- `done`  out  1  one-cycle pulse at frame end

## Operation
- Reset values: `count`=0, `reg_data`=0, `in_ready`=0, `busy`=0, `done`=0, state IDLE.
- States: IDLE, CLEAR, STREAM, DONE.
- IDLE: outputs hold. `start`=1 -> CLEAR.
- CLEAR (1 cycle): `count`<=0, `reg_data`<=0 -> STREAM.
- STREAM: `in_ready`=1 (combinational from state). On handshake: `count`<=`count`+1, `reg_data`<=`in_data` in the same edge, so both change together. No handshake: both hold. Handshake that loads `count`=TOTAL-1 -> DONE.
- DONE (1 cycle): `done`=1, `in_ready`=0 -> IDLE.
- After a frame, `count`=TOTAL-1 and `reg_data`=last word hold until the next CLEAR.
- `start` outside IDLE is ignored, not queued.
- `in_valid` outside STREAM is not accepted.
- `count` never exceeds TOTAL-1; there is no wrap inside a frame.
- `rst` mid-frame: next cycle all outputs at reset values, state IDLE. Partial frame is discarded.

## Timing
- `start` at edge N: `count`=0 visible after N+1. First handshake possible in the cycle after N+1.
- Handshake at edge M: new `count`/`reg_data` visible after M.
- Last handshake at edge L: `done`=1 during cycle L..L+1. IDLE from L+1, and a new `start` is sampled at L+2.
- Minimum frame length with `in_valid` held high: 1 + (TOTAL-1) + 1 = TOTAL+1 cycles from `start`.

## Configuration
- `MRF_FEEDER_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort`=1 in CLEAR or STREAM: next state IDLE, `count`<=0, `reg_data`<=0, `busy`=0, no `done`.
  - `abort` has priority over a simultaneous handshake; that word is not accepted (`in_ready` forced 0 while `abort`=1).
  - `abort` in IDLE or DONE: no effect.
- Undefined: no `abort` port; frames always run to completion or `rst`.

## Structure
- Shared package `mrf_pkg`:
  - state enum `mrf_feeder_state_t` {IDLE, CLEAR, STREAM, DONE}
  - default constants for `WORDWIDTH`/`NUM1`/`CHANNEL`
  - function computing `TOTAL` and `CW`
- Sub-module `mrf_word_counter`: CW-bit counter with sync clear, increment enable, and terminal flag (`count`==TOTAL-1).
- FSM and data register live in `mrf_feeder`.

## Test plan
All scenarios use defaults: TOTAL=30, 29 words.
- Reset with `in_valid`=1 and `start`=1 held in the same cycle -> all outputs 0 the next cycle, `in_ready`=0.
- `start`, then words 0x1..0x1D streamed back-to-back -> `count` 0,1..29 on consecutive cycles, `reg_data`=word i at `count`=i. `done` pulses once, 31 cycles after `start`. Outputs then hold 29/0x1D.
- Same frame with `in_valid` toggled 1,0,1,0 -> `count` and `reg_data` hold during gaps, no word skipped or duplicated, `done` after word 29.
- `start` pulsed mid-STREAM and again in DONE -> ignored, `count` sequence unchanged.
- `rst` asserted at `count`=12 -> next cycle `count`=0, `busy`=0, no `done`. A new `start` runs a full clean frame.
- With `MRF_FEEDER_ABORT_EN`: `abort` at `count`=7 with `in_valid`=1 -> word not accepted, next cycle `count`=0, `reg_data`=0, IDLE, no `done`.
